// File: rtl/e203_exu_flush_arbiter.sv
// Flush arbiter: shares the single IFU flush port between branch-class and
// exception-class requesters, computes the target PC with one registered adder.
module e203_exu_flush_arbiter #(
    parameter int PC_SIZE = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               brch_req,
    input  logic [PC_SIZE-1:0] brch_op1,
    input  logic [PC_SIZE-1:0] brch_op2,
    output logic               brch_ack,
    input  logic               excp_req,
    input  logic [PC_SIZE-1:0] excp_op1,
    input  logic [PC_SIZE-1:0] excp_op2,
    output logic               excp_ack,
    output logic               ifu_flush_req,
    output logic [PC_SIZE-1:0] ifu_flush_pc,
    input  logic               ifu_flush_ack,
    output logic               busy,
    output logic [CNT_W-1:0]   cnt_brch,
    output logic [CNT_W-1:0]   cnt_excp,
    output logic [CNT_W-1:0]   cnt_preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic SRC_BRCH = 1'b0;
    localparam logic SRC_EXCP = 1'b1;

    state_t             state_r;
    logic               src_r;
    logic [PC_SIZE-1:0] op1_r;
    logic [PC_SIZE-1:0] op2_r;
    logic [PC_SIZE-1:0] pc_r;
    logic               req_r;
    logic               brch_ack_r;
    logic               excp_ack_r;
    logic               busy_r;
    logic [CNT_W-1:0]   cnt_brch_r;
    logic [CNT_W-1:0]   cnt_excp_r;
    logic [CNT_W-1:0]   cnt_preempt_r;

    // Carry-out is dropped and the result is halfword aligned.
    function automatic logic [PC_SIZE-1:0] target_pc(input logic [PC_SIZE-1:0] a,
                                                     input logic [PC_SIZE-1:0] b);
        logic [PC_SIZE-1:0] sum;
        sum    = a + b;
        sum[0] = 1'b0;
        return sum;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end else begin
            return c + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Flush sequencing FSM with all outputs and statistics registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            src_r         <= SRC_BRCH;
            op1_r         <= {PC_SIZE{1'b0}};
            op2_r         <= {PC_SIZE{1'b0}};
            pc_r          <= {PC_SIZE{1'b0}};
            req_r         <= 1'b0;
            brch_ack_r    <= 1'b0;
            excp_ack_r    <= 1'b0;
            busy_r        <= 1'b0;
            cnt_brch_r    <= {CNT_W{1'b0}};
            cnt_excp_r    <= {CNT_W{1'b0}};
            cnt_preempt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    brch_ack_r <= 1'b0;
                    excp_ack_r <= 1'b0;
                    req_r      <= 1'b0;
                    if (excp_req) begin
                        op1_r   <= excp_op1;
                        op2_r   <= excp_op2;
                        src_r   <= SRC_EXCP;
                        state_r <= CALC;
                        busy_r  <= 1'b1;
                    end else if (brch_req) begin
                        op1_r   <= brch_op1;
                        op2_r   <= brch_op2;
                        src_r   <= SRC_BRCH;
                        state_r <= CALC;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                CALC: begin
                    // An exception arriving before issue supersedes a pending branch.
                    if ((src_r == SRC_BRCH) && excp_req) begin
                        op1_r         <= excp_op1;
                        op2_r         <= excp_op2;
                        src_r         <= SRC_EXCP;
                        cnt_preempt_r <= sat_inc(cnt_preempt_r);
                        state_r       <= CALC;
                    end else begin
                        pc_r    <= target_pc(op1_r, op2_r);
                        req_r   <= 1'b1;
                        state_r <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ifu_flush_ack) begin
                        req_r      <= 1'b0;
                        brch_ack_r <= (src_r == SRC_BRCH);
                        excp_ack_r <= (src_r == SRC_EXCP);
                        state_r    <= DONE;
                    end else begin
                        req_r   <= 1'b1;
                        state_r <= ISSUE;
                    end
                end
                DONE: begin
                    brch_ack_r <= 1'b0;
                    excp_ack_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                    if (src_r == SRC_EXCP) begin
                        cnt_excp_r <= sat_inc(cnt_excp_r);
                    end else begin
                        cnt_brch_r <= sat_inc(cnt_brch_r);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    req_r      <= 1'b0;
                    brch_ack_r <= 1'b0;
                    excp_ack_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign brch_ack      = brch_ack_r;
    assign excp_ack      = excp_ack_r;
    assign ifu_flush_req = req_r;
    assign ifu_flush_pc  = pc_r;
    assign busy          = busy_r;
    assign cnt_brch      = cnt_brch_r;
    assign cnt_excp      = cnt_excp_r;
    assign cnt_preempt   = cnt_preempt_r;

endmodule

// File: tb/tb_e203_exu_flush_arbiter.sv
// Directed bench for the flush arbiter; counters are narrowed to 4 bits so
// saturation is reachable quickly.
module tb_e203_exu_flush_arbiter;

    localparam int PC_SIZE = 32;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               brch_req = 1'b0;
    logic [PC_SIZE-1:0] brch_op1 = 32'h0;
    logic [PC_SIZE-1:0] brch_op2 = 32'h0;
    logic               brch_ack;
    logic               excp_req = 1'b0;
    logic [PC_SIZE-1:0] excp_op1 = 32'h0;
    logic [PC_SIZE-1:0] excp_op2 = 32'h0;
    logic               excp_ack;
    logic               ifu_flush_req;
    logic [PC_SIZE-1:0] ifu_flush_pc;
    logic               ifu_flush_ack = 1'b0;
    logic               busy;
    logic [CNT_W-1:0]   cnt_brch;
    logic [CNT_W-1:0]   cnt_excp;
    logic [CNT_W-1:0]   cnt_preempt;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_brch = 4'h0;
    logic [CNT_W-1:0] exp_excp = 4'h0;
    logic [CNT_W-1:0] exp_pre  = 4'h0;

    e203_exu_flush_arbiter #(.PC_SIZE(PC_SIZE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .brch_req(brch_req), .brch_op1(brch_op1), .brch_op2(brch_op2), .brch_ack(brch_ack),
        .excp_req(excp_req), .excp_op1(excp_op1), .excp_op2(excp_op2), .excp_ack(excp_ack),
        .ifu_flush_req(ifu_flush_req), .ifu_flush_pc(ifu_flush_pc), .ifu_flush_ack(ifu_flush_ack),
        .busy(busy), .cnt_brch(cnt_brch), .cnt_excp(cnt_excp), .cnt_preempt(cnt_preempt)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
        return (c == 4'hF) ? c : c + 4'h1;
    endfunction

    // Waits (bounded) for ifu_flush_req; returns negedges elapsed and timeout flag.
    task automatic wait_req(output int n, output logic to);
        @(negedge clk);
        n = 1;
        while (ifu_flush_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        to = (ifu_flush_req !== 1'b1);
    endtask

    // One complete flush from a single requester; ends on the IDLE cycle.
    task automatic run_flush(input logic is_excp, input logic [31:0] o1, input logic [31:0] o2,
                             output logic [31:0] pc, output int lat, output logic ab,
                             output logic ae, output logic to);
        if (is_excp) begin
            excp_req = 1'b1; excp_op1 = o1; excp_op2 = o2;
        end else begin
            brch_req = 1'b1; brch_op1 = o1; brch_op2 = o2;
        end
        wait_req(lat, to);
        pc = ifu_flush_pc;
        ifu_flush_ack = 1'b1;
        @(negedge clk);
        ab = brch_ack;
        ae = excp_ack;
        ifu_flush_ack = 1'b0;
        brch_req = 1'b0;
        excp_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifu_flush_req, brch_ack, excp_ack, busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000", {ifu_flush_req, brch_ack, excp_ack, busy});
        end
        checks++;
        if (ifu_flush_pc !== 32'h0 || {cnt_brch, cnt_excp, cnt_preempt} !== 12'h000) begin
            errors++; $display("FAIL reset_data: pc=%h cnt=%h want 0", ifu_flush_pc, {cnt_brch, cnt_excp, cnt_preempt});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_branch();
        logic [31:0] pc; int lat; logic ab, ae, to;
        run_flush(1'b0, 32'h8000_0100, 32'h0000_0010, pc, lat, ab, ae, to);
        exp_brch = sat(exp_brch);
        checks++;
        if (to || lat != 2) begin
            errors++; $display("FAIL brch_latency: got %0d (timeout %b) want 2", lat, to);
        end
        checks++;
        if (pc !== 32'h8000_0110) begin
            errors++; $display("FAIL brch_pc: got %h want 80000110", pc);
        end
        checks++;
        if ({ab, ae} !== 2'b10) begin
            errors++; $display("FAIL brch_ack: got %b want 10", {ab, ae});
        end
        checks++;
        if (brch_ack !== 1'b0 || busy !== 1'b0 || cnt_brch !== exp_brch) begin
            errors++; $display("FAIL brch_after: ack=%b busy=%b cnt=%h want 0 0 %h", brch_ack, busy, cnt_brch, exp_brch);
        end
    endtask

    task automatic test_simultaneous();
        int lat; logic to;
        brch_req = 1'b1; brch_op1 = 32'h8000_0200; brch_op2 = 32'h0000_0004;
        excp_req = 1'b1; excp_op1 = 32'h8000_0000; excp_op2 = 32'h0;
        wait_req(lat, to);
        checks++;
        if (to || ifu_flush_pc !== 32'h8000_0000) begin
            errors++; $display("FAIL simul_excp_pc: got %h (timeout %b) want 80000000", ifu_flush_pc, to);
        end
        ifu_flush_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({brch_ack, excp_ack} !== 2'b01) begin
            errors++; $display("FAIL simul_excp_ack: got %b want 01", {brch_ack, excp_ack});
        end
        ifu_flush_ack = 1'b0;
        excp_req = 1'b0;
        exp_excp = sat(exp_excp);
        wait_req(lat, to);
        checks++;
        if (to || ifu_flush_pc !== 32'h8000_0204) begin
            errors++; $display("FAIL simul_brch_pc: got %h (timeout %b) want 80000204", ifu_flush_pc, to);
        end
        ifu_flush_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({brch_ack, excp_ack} !== 2'b10) begin
            errors++; $display("FAIL simul_brch_ack: got %b want 10", {brch_ack, excp_ack});
        end
        ifu_flush_ack = 1'b0;
        brch_req = 1'b0;
        exp_brch = sat(exp_brch);
        @(negedge clk);
        checks++;
        if (cnt_excp !== exp_excp || cnt_brch !== exp_brch) begin
            errors++; $display("FAIL simul_cnt: got e=%h b=%h want e=%h b=%h", cnt_excp, cnt_brch, exp_excp, exp_brch);
        end
    endtask

    task automatic test_preempt();
        int lat; logic to;
        brch_req = 1'b1; brch_op1 = 32'h4000_0000; brch_op2 = 32'h0000_0020;
        @(negedge clk);
        excp_req = 1'b1; excp_op1 = 32'h0000_1000; excp_op2 = 32'h0000_0040;
        @(negedge clk);
        exp_pre = sat(exp_pre);
        checks++;
        if (ifu_flush_req !== 1'b0 || cnt_preempt !== exp_pre) begin
            errors++; $display("FAIL preempt_calc: req=%b cnt=%h want 0 %h", ifu_flush_req, cnt_preempt, exp_pre);
        end
        brch_req = 1'b0;
        wait_req(lat, to);
        checks++;
        if (to || ifu_flush_pc !== 32'h0000_1040) begin
            errors++; $display("FAIL preempt_pc: got %h (timeout %b) want 00001040", ifu_flush_pc, to);
        end
        ifu_flush_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({brch_ack, excp_ack} !== 2'b01) begin
            errors++; $display("FAIL preempt_ack: got %b want 01", {brch_ack, excp_ack});
        end
        ifu_flush_ack = 1'b0;
        excp_req = 1'b0;
        exp_excp = sat(exp_excp);
        @(negedge clk);
        checks++;
        if (brch_ack !== 1'b0 || cnt_brch !== exp_brch || cnt_excp !== exp_excp) begin
            errors++; $display("FAIL preempt_cnt: ack=%b b=%h e=%h want 0 %h %h", brch_ack, cnt_brch, cnt_excp, exp_brch, exp_excp);
        end
    endtask

    task automatic test_stall();
        int lat; logic to; int bad;
        brch_req = 1'b1; brch_op1 = 32'h2000_0000; brch_op2 = 32'h0000_0008;
        wait_req(lat, to);
        bad = to ? 1 : 0;
        excp_req = 1'b1; excp_op1 = 32'h3000_0000; excp_op2 = 32'h0000_0100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifu_flush_req !== 1'b1 || ifu_flush_pc !== 32'h2000_0008 || excp_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stall_hold: %0d bad cycles, last req=%b pc=%h want 1 20000008", bad, ifu_flush_req, ifu_flush_pc);
        end
        ifu_flush_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({brch_ack, excp_ack} !== 2'b10) begin
            errors++; $display("FAIL stall_brch_ack: got %b want 10", {brch_ack, excp_ack});
        end
        ifu_flush_ack = 1'b0;
        brch_req = 1'b0;
        exp_brch = sat(exp_brch);
        wait_req(lat, to);
        checks++;
        if (to || ifu_flush_pc !== 32'h3000_0100) begin
            errors++; $display("FAIL stall_excp_pc: got %h (timeout %b) want 30000100", ifu_flush_pc, to);
        end
        ifu_flush_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({brch_ack, excp_ack} !== 2'b01) begin
            errors++; $display("FAIL stall_excp_ack: got %b want 01", {brch_ack, excp_ack});
        end
        ifu_flush_ack = 1'b0;
        excp_req = 1'b0;
        exp_excp = sat(exp_excp);
        @(negedge clk);
    endtask

    task automatic test_wrap_align();
        logic [31:0] pc; int lat; logic ab, ae, to;
        logic [31:0] op1_v [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0100};
        logic [31:0] op2_v [3] = '{32'h0000_0003, 32'h0000_0004, 32'h0000_0001};
        logic [31:0] pc_v  [3] = '{32'h0000_0002, 32'h0000_0002, 32'h0000_0100};
        for (int i = 0; i < 3; i++) begin
            run_flush(1'b0, op1_v[i], op2_v[i], pc, lat, ab, ae, to);
            exp_brch = sat(exp_brch);
            checks++;
            if (to || pc !== pc_v[i] || ab !== 1'b1) begin
                errors++; $display("FAIL wrap_pc[%0d]: got %h ack=%b want %h 1", i, pc, ab, pc_v[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] pc; int lat; logic ab, ae, to; int bad;
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            run_flush(1'b0, 32'h0000_0010, 32'h0000_0010, pc, lat, ab, ae, to);
            exp_brch = sat(exp_brch);
            if (to || cnt_brch !== exp_brch) begin
                bad++;
                $display("FAIL sat_step[%0d]: got %h want %h", i, cnt_brch, exp_brch);
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (cnt_brch !== 4'hF) begin
            errors++; $display("FAIL sat_hold: got %h want f", cnt_brch);
        end
    endtask

    task automatic test_reset_mid_issue();
        int lat; logic to;
        brch_req = 1'b1; brch_op1 = 32'h1234_0000; brch_op2 = 32'h0000_0010;
        wait_req(lat, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL rst_issue_reach: req=%b want 1", ifu_flush_req);
        end
        brch_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (ifu_flush_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_issue_drop: req=%b busy=%b want 0 0", ifu_flush_req, busy);
        end
        ifu_flush_ack = 1'b1;
        @(negedge clk);
        ifu_flush_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({brch_ack, excp_ack, busy} !== 3'b000 || {cnt_brch, cnt_excp, cnt_preempt} !== 12'h000) begin
            errors++; $display("FAIL rst_issue_after: ack/busy=%b cnt=%h want 000 000", {brch_ack, excp_ack, busy}, {cnt_brch, cnt_excp, cnt_preempt});
        end
    endtask

    // Mutual exclusion of the two ack pulses over the whole run.
    always @(negedge clk) begin
        if (rst_n && brch_ack === 1'b1 && excp_ack === 1'b1) begin
            errors++;
            $display("FAIL ack_exclusive: got brch_ack=1 excp_ack=1 want not both");
        end
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_branch();
        test_simultaneous();
        test_preempt();
        test_stall();
        test_wrap_align();
        test_saturation();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/e203_exu_flush_arbiter.md
Name: e203_exu_flush_arbiter

Overview:
- Sequences the single IFU flush port between two requesters: branch-mispredict/fence.i/mret/dret resolution (brch) and non-ALU exception/interrupt (excp).
- Latches the winning request and computes the target PC with one registered adder, replacing the duplicated combinational adders.
- Holds the IFU request stable until acknowledged, then returns a one-cycle ack to the winning requester.
- Sits between the commit stage and the IFU; also keeps per-source flush statistics.

Parameters:
- PC_SIZE, 32, width of PC and adder operands.
- CNT_W, 16, width of each saturating statistics counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- brch_req  in  1  branch-class flush request; held until brch_ack
- brch_op1  in  PC_SIZE  branch target operand 1 (PC / EPC / DPC)
- brch_op2  in  PC_SIZE  branch target operand 2 (imm / 2 / 4 / 0)
- brch_ack  out  1  one-cycle pulse: branch flush completed
- excp_req  in  1  exception/irq flush request; held until excp_ack
- excp_op1  in  PC_SIZE  exception target operand 1 (mtvec base)
- excp_op2  in  PC_SIZE  exception target operand 2 (vector offset or 0)
- excp_ack  out  1  one-cycle pulse: exception flush completed
- ifu_flush_req  out  1  flush request to IFU
- ifu_flush_pc  out  PC_SIZE  flush target PC
- ifu_flush_ack  in  1  IFU accepts flush
- busy  out  1  state != IDLE
- cnt_brch  out  CNT_W  completed branch flushes, saturating
- cnt_excp  out  CNT_W  completed exception flushes, saturating
- cnt_preempt  out  CNT_W  branch requests preempted by exception, saturating

Behaviour:
- States: IDLE, CALC, ISSUE, DONE; 2-bit encoded.
- Reset (sync, rst_n=0): state=IDLE; src=0; op registers=0; ifu_flush_pc=0; all outputs 0; counters 0. Reset mid-ISSUE drops ifu_flush_req the following cycle; the aborted flush is not counted.
- IDLE:
  - If excp_req, capture excp ops, src=EXCP, go to CALC.
  - Else if brch_req, capture brch ops, src=BRCH, go to CALC.
  - Exception has fixed priority when both requests are asserted.
- CALC:
  - ifu_flush_pc <= (op1 + op2) mod 2^PC_SIZE, with bit0 forced to 0; go to ISSUE.
  - Preemption: if src=BRCH and excp_req=1 in this cycle, recapture excp ops, src=EXCP, stay in CALC, cnt_preempt++.
  - The branch requester is not acked on preemption; it is expected to drop brch_req because the exception flushes it.
- ISSUE:
  - ifu_flush_req=1; ifu_flush_pc and src are frozen (no preemption).
  - On ifu_flush_ack=1, go to DONE.
  - If ack never arrives, stay in ISSUE indefinitely.
- DONE:
  - Pulse brch_ack or excp_ack per src for exactly one cycle.
  - Increment the matching counter; go to IDLE.
  - The requester deasserts its req in the cycle after its ack; IDLE ignores nothing special.
  - A requester still asserting req in IDLE starts a new flush.
- Latency: req in IDLE -> ifu_flush_req after 2 cycles (IDLE capture, CALC); ifu_flush_ack -> requester ack after 1 cycle. Minimum 4 cycles between back-to-back flushes.
- Handshake:
  - ifu_flush_req is a registered output, asserted only in ISSUE.
  - ifu_flush_ack is ignored outside ISSUE.
  - brch_ack and excp_ack are never asserted together.
- Arithmetic: adder carry-out is discarded (wrap-around), e.g. 0xFFFF_FFFE + 4 = 0x0000_0002.
- Counters: increment only in DONE (cnt_preempt only on a CALC preemption). They hold at all-ones (saturate) and never wrap.
- busy=1 in CALC, ISSUE and DONE.

Test Plan:
- Branch flush: brch_req=1, op1=0x8000_0100, op2=0x10, ack on first ISSUE cycle -> ifu_flush_req on cycle 2 with pc=0x8000_0110; brch_ack pulses one cycle later; cnt_brch=1.
- Simultaneous requests: brch_req and excp_req in the same IDLE cycle, excp_op1=0x8000_0000, excp_op2=0 -> pc=0x8000_0000; excp_ack only; then brch (still held) issues its own flush; cnt_excp=1, cnt_brch=1.
- Preemption: brch captured, excp_req rises in CALC -> issued pc is the exception target; cnt_preempt=1; no brch_ack for the preempted request.
- Stall plus late exception: ifu_flush_ack held low for 10 cycles in ISSUE while excp_req rises -> pc and src unchanged, req stays high; after ack the branch completes, then the exception is served.
- Wrap, alignment and saturation: op1=0xFFFF_FFFF, op2=3 -> pc=0x0000_0002; cnt_brch preloaded near all-ones via 2^CNT_W+2 flushes with CNT_W=4 -> counter holds at 0xF.
- Reset mid-ISSUE: rst_n=0 for one cycle -> ifu_flush_req=0 and busy=0 next cycle; no ack pulse; counters 0.
